// File: rtl/serial_adder_tx.sv
// Parallel-in, serial-out adder/subtractor: one full adder plus a carry flop, LSB first.
// Latency: serial bits in cycles 1..WIDTH after acceptance, done pulse in cycle WIDTH+1.
// Backpressure: none downstream; upstream sees ready only in IDLE, start ignored otherwise.
module serial_adder_tx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             s_bit,
    output logic             s_valid,
    output logic             s_last,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int              CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_t             state;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic               carry;
    logic [CW-1:0]      count;

    logic               fa_sum;
    logic               fa_carry;
    logic               in_shift;
    logic               at_msb;

    // Single full adder working on the current LSBs of the operand shifters.
    always_comb begin
        fa_sum   = a_sr[0] ^ b_sr[0] ^ carry;
        fa_carry = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    end

    assign in_shift = (state == SHIFT);
    assign at_msb   = (count == LAST);

    // Serial stream is forced low outside SHIFT so consumers never see stale adder output.
    assign s_bit   = in_shift & fa_sum;
    assign s_valid = in_shift;
    assign s_last  = in_shift & at_msb;
    assign ready   = (state == IDLE);
    assign done    = (state == DONE);

    // Control FSM and datapath registers; subtraction is a + ~b + 1 via the carry seed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            carry <= 1'b0;
            count <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= sub ? ~b : b;
                        carry <= sub;
                        count <= '0;
                        sum   <= '0;
                        cout  <= 1'b0;
                        ovf   <= 1'b0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    carry <= fa_carry;
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    sum   <= {fa_sum, sum[WIDTH-1:1]};
                    count <= count + 1'b1;
                    if (at_msb) begin
                        // carry still holds the carry into the MSB at this edge
                        cout  <= fa_carry;
                        ovf   <= carry ^ fa_carry;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_tx.sv
`timescale 1ns/1ps
module tb_serial_adder_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b0;

    // WIDTH=4 instance
    logic       start = 1'b0;
    logic       sub_i = 1'b0;
    logic [3:0] a_i = '0;
    logic [3:0] b_i = '0;
    logic       ready, s_bit, s_valid, s_last, cout, ovf, done;
    logic [3:0] sum;

    // WIDTH=8 instance
    logic       start8 = 1'b0;
    logic       sub8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       ready8, s_bit8, s_valid8, s_last8, cout8, ovf8, done8;
    logic [7:0] sum8;

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic [3:0] sum;
        logic       cout;
        logic       ovf;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    serial_adder_tx #(.WIDTH(4)) dut (
        .clk(clk), .reset(reset), .start(start), .sub(sub_i), .a(a_i), .b(b_i),
        .ready(ready), .s_bit(s_bit), .s_valid(s_valid), .s_last(s_last),
        .sum(sum), .cout(cout), .ovf(ovf), .done(done)
    );

    serial_adder_tx #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .ready(ready8), .s_bit(s_bit8), .s_valid(s_valid8), .s_last(s_last8),
        .sum(sum8), .cout(cout8), .ovf(ovf8), .done(done8)
    );

    // Reference arithmetic: 5-bit sum of a and the (possibly inverted) b plus the subtract seed.
    function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input logic s);
        exp_t       e;
        logic [3:0] bb;
        logic [4:0] r;
        bb     = s ? ~b : b;
        r      = {1'b0, a} + {1'b0, bb} + {4'b0000, s};
        e.sum  = r[3:0];
        e.cout = r[4];
        e.ovf  = (a[3] == bb[3]) && (r[3] != a[3]);
        return e;
    endfunction

    // Scoreboard monitor: gathers the serial stream and checks it plus the parallel result at done.
    initial begin
        logic [3:0] ser;
        int         nbits;
        exp_t       e;
        ser   = '0;
        nbits = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                ser   = '0;
                nbits = 0;
            end else begin
                if (s_valid) begin
                    total++;
                    if (s_last !== (nbits == 3)) $display("FAIL s_last_pos bit=%0d got=%b want=%b", nbits, s_last, (nbits == 3));
                    else passed++;
                    ser   = {s_bit, ser[3:1]};
                    nbits++;
                end
                if (done) begin
                    total++;
                    if (sb.size() == 0) begin
                        $display("FAIL unexpected_done got=done want=no_done");
                    end else begin
                        passed++;
                        e = sb.pop_front();
                        total++;
                        if (nbits !== 4) $display("FAIL serial_count got=%0d want=4", nbits);
                        else passed++;
                        total++;
                        if (ser !== e.sum) $display("FAIL serial_bits got=%b want=%b", ser, e.sum);
                        else passed++;
                        total++;
                        if (sum !== e.sum) $display("FAIL sum got=%b want=%b", sum, e.sum);
                        else passed++;
                        total++;
                        if (cout !== e.cout) $display("FAIL cout got=%b want=%b", cout, e.cout);
                        else passed++;
                        total++;
                        if (ovf !== e.ovf) $display("FAIL ovf got=%b want=%b", ovf, e.ovf);
                        else passed++;
                    end
                    ser   = '0;
                    nbits = 0;
                end
            end
        end
    end

    // Present an operation on the negedge so it is accepted on the following rising edge.
    task automatic accept4(input logic [3:0] a, input logic [3:0] b, input logic s);
        @(negedge clk);
        a_i   = a;
        b_i   = b;
        sub_i = s;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done();
        bit got;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1;
        end
        total++;
        if (!got) $display("FAIL done_timeout got=no_done want=done");
        else passed++;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        a_i   = 4'hF;
        b_i   = 4'hF;
        start = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({ready, s_bit, s_valid, s_last, sum, cout, ovf, done} !== 11'b100_0000_0000)
            $display("FAIL reset_outputs got=%b want=%b",
                     {ready, s_bit, s_valid, s_last, sum, cout, ovf, done}, 11'b100_0000_0000);
        else passed++;
        start = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if ({s_valid, done, sum, cout, ovf, ready} !== 9'b0_0_0000_0_0_1)
                $display("FAIL idle_quiet cyc=%0d got=%b want=%b", i,
                         {s_valid, done, sum, cout, ovf, ready}, 9'b0_0_0000_0_0_1);
            else passed++;
        end
    endtask

    task automatic test_add_timing();
        logic [3:0] tbl [1:6];
        // {s_valid, s_last, done, ready} per cycle after acceptance
        tbl = '{4'b1000, 4'b1000, 4'b1000, 4'b1100, 4'b0010, 4'b0001};
        sb.push_back(model(4'd5, 4'd6, 1'b0));
        accept4(4'd5, 4'd6, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            total++;
            if ({s_valid, s_last, done, ready} !== tbl[c])
                $display("FAIL frame_timing cyc=%0d got=%b want=%b", c, {s_valid, s_last, done, ready}, tbl[c]);
            else passed++;
        end
    endtask

    task automatic test_arith();
        logic [8:0] ops [6];
        ops = '{{4'd15, 4'd1, 1'b0}, {4'd3, 4'd5, 1'b1}, {4'd7, 4'd8, 1'b1},
                {4'd0, 4'd0, 1'b1}, {4'd8, 4'd8, 1'b0}, {4'd12, 4'd3, 1'b1}};
        for (int i = 0; i < 6; i++) begin
            sb.push_back(model(ops[i][8:5], ops[i][4:1], ops[i][0]));
            accept4(ops[i][8:5], ops[i][4:1], ops[i][0]);
            wait_done();
        end
        for (int i = 0; i < 6; i++) begin
            logic [3:0] ra, rb;
            logic       rs;
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rs = 1'($urandom_range(0, 1));
            sb.push_back(model(ra, rb, rs));
            accept4(ra, rb, rs);
            wait_done();
        end
    endtask

    task automatic test_inputs_ignored();
        sb.push_back(model(4'd9, 4'd4, 1'b1));
        accept4(4'd9, 4'd4, 1'b1);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            a_i   = 4'($urandom_range(0, 15));
            b_i   = 4'($urandom_range(0, 15));
            sub_i = 1'($urandom_range(0, 1));
            start = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [19:0] rmask, emask;
        for (int i = 0; i < 4; i++) sb.push_back(model(4'd6, 4'd7, 1'b0));
        @(negedge clk);
        a_i   = 4'd6;
        b_i   = 4'd7;
        sub_i = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            rmask[i] = ready;
            emask[i] = ((i % 6) == 0);
            @(posedge clk);
        end
        #1 start = 1'b0;
        wait_done();
        total++;
        if (rmask !== emask) $display("FAIL accept_pattern got=%b want=%b", rmask, emask);
        else passed++;
    endtask

    task automatic test_reset_mid();
        bit seen;
        accept4(4'd9, 4'd3, 1'b0);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        total++;
        if ({ready, s_bit, s_valid, s_last, sum, cout, ovf, done} !== 11'b100_0000_0000)
            $display("FAIL mid_reset_outputs got=%b want=%b",
                     {ready, s_bit, s_valid, s_last, sum, cout, ovf, done}, 11'b100_0000_0000);
        else passed++;
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        total++;
        if (seen) $display("FAIL aborted_done got=done want=no_done");
        else passed++;
        sb.push_back(model(4'd2, 4'd2, 1'b0));
        accept4(4'd2, 4'd2, 1'b0);
        wait_done();
    endtask

    task automatic test_width8();
        int         nv, last_at;
        bit         got;
        logic [7:0] ser8;
        nv      = 0;
        last_at = -1;
        got     = 0;
        ser8    = '0;
        @(negedge clk);
        a8     = 8'hFF;
        b8     = 8'h01;
        sub8   = 1'b0;
        start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (s_valid8) begin
                nv++;
                ser8 = {s_bit8, ser8[7:1]};
                if (s_last8) last_at = nv;
            end
            if (done8) got = 1;
        end
        total++;
        if (!got) $display("FAIL w8_done got=no_done want=done");
        else passed++;
        total++;
        if (nv !== 8) $display("FAIL w8_valid_bits got=%0d want=8", nv);
        else passed++;
        total++;
        if (last_at !== 8) $display("FAIL w8_last_pos got=%0d want=8", last_at);
        else passed++;
        total++;
        if ({ser8, sum8, cout8, ovf8} !== {8'h00, 8'h00, 1'b1, 1'b0})
            $display("FAIL w8_result got=%h/%h/%b/%b want=00/00/1/0", ser8, sum8, cout8, ovf8);
        else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add_timing();
        test_arith();
        test_inputs_ignored();
        test_back_to_back();
        test_reset_mid();
        test_width8();
        repeat (4) @(negedge clk);
        total++;
        if (sb.size() !== 0) $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/serial_adder_tx.md
# serial_adder_tx

Parallel-in, serial-out adder/subtractor that runs the opposite direction to the team's serial-in adder chain. It accepts two WIDTH-bit operands in parallel on a start handshake, clocks them through a single full adder and a carry flip-flop LSB-first, and emits the sum as a serial bit stream with valid/last framing. It also assembles the parallel result with carry and signed-overflow flags. It feeds serial consumers such as the serial adder datapath or a bit-serial link, and it is driven by a parallel-word producer.

## Interface
- WIDTH, 4, operand and result width in bits (WIDTH >= 2)

- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately when low
- start  in  1  request to begin an operation; accepted only when ready=1
- sub  in  1  0: a+b, 1: a-b (two's complement); sampled at acceptance
- a  in  WIDTH  operand A; sampled at acceptance
- b  in  WIDTH  operand B; sampled at acceptance
- ready  out  1  high in IDLE only
- s_bit  out  1  current serial sum bit, LSB first
- s_valid  out  1  s_bit is valid this cycle
- s_last  out  1  high with the MSB bit (coincident with s_valid)
- sum  out  WIDTH  assembled parallel result
- cout  out  1  final carry out (for sub: 1 = no borrow)
- ovf  out  1  signed overflow (carry into MSB XOR carry out of MSB)
- done  out  1  one-cycle pulse after the last serial bit

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE → SHIFT when start=1 at a clock edge.
- On acceptance:
  - a_sr ← a
  - b_sr ← sub ? ~b : b
  - carry ← sub
  - bit counter ← 0
  - sum is cleared to 0; cout and ovf are cleared.
- SHIFT:
  - Combinational: s_bit = a_sr[0] ^ b_sr[0] ^ carry; s_valid=1; s_last = (count==WIDTH-1).
  - Each edge: carry ← majority(a_sr[0], b_sr[0], carry).
  - Each edge: a_sr and b_sr shift right one bit.
  - Each edge: sum shifts right with s_bit entering the MSB; count increments.
  - On the edge where count==WIDTH-1: capture cout ← new carry, capture ovf ← carry_in_of_MSB ^ new carry, then → DONE.
- DONE: done=1 for exactly one cycle, then → IDLE.
- Outside SHIFT: s_valid=0, s_last=0, s_bit=0.
- sum, cout and ovf hold their values from the end of DONE until the next acceptance.
- start, a, b and sub are ignored outside IDLE. Changing them mid-operation has no effect.
- Arithmetic is modulo 2^WIDTH; no saturation.

## Timing
- Reset (reset=0, asynchronous):
  - state=IDLE, ready=1
  - all registers 0
  - s_bit, s_valid, s_last, sum, cout, ovf, done all 0
- Reset asserted mid-SHIFT or mid-DONE aborts the operation: no done pulse, partial sum discarded.
- Cycle numbering: acceptance edge is E0.
  - Cycles 1..WIDTH: s_valid=1, carrying sum bits 0..WIDTH-1.
  - Cycle WIDTH: s_last=1.
  - Cycle WIDTH+1: done=1; sum, cout and ovf are final and valid.
  - Cycle WIDTH+2: ready=1.
- Throughput: one operation per WIDTH+2 cycles.
- start held high continuously is accepted at every IDLE cycle. There is no gap between done and the next acceptance beyond the single IDLE cycle.

## Test plan
- Add, WIDTH=4, a=5, b=6, sub=0 → s_bit over cycles 1..4 = 1,1,0,1; s_last in cycle 4; done in cycle 5; sum=4'b1011, cout=0, ovf=1.
- Add with wrap, a=15, b=1, sub=0 → serial 0,0,0,0; sum=0, cout=1, ovf=0.
- Subtract, a=3, b=5, sub=1 → serial 0,1,1,1; sum=4'b1110 (-2), cout=0 (borrow), ovf=0. Second case a=7, b=8, sub=1 → sum=4'b1111, cout=0, ovf=1.
- Handshake:
  - start held high for 20 cycles → acceptances at E0, E6, E12, E18; ready low between them.
  - Changing a, b and sub during SHIFT does not alter the serial stream.
- Reset mid-operation: accept a=9, b=3, drive reset=0 during cycle 2 → outputs 0 immediately, ready=1, no done pulse. A following operation a=2, b=2 gives sum=4, cout=0, ovf=0.
- Idle checks:
  - After reset with start=0: s_valid, done, sum, cout and ovf stay 0 indefinitely.
  - With WIDTH=8, a=8'hFF, b=8'h01, sub=0: 8 valid bits, s_last on bit 8, sum=0, cout=1.
